// File: rtl/spi_pkg.sv
// Shared encodings for the SPI target: FSM states and the
// edge-selection constants used to pick sample/shift edges.
package spi_pkg;

    localparam logic [0:0] ST_IDLE   = 1'b0;
    localparam logic [0:0] ST_ACTIVE = 1'b1;

    localparam logic EDGE_LEAD  = 1'b0;
    localparam logic EDGE_TRAIL = 1'b1;

    function automatic logic sample_edge_sel(input int cpha);
        return (cpha != 0) ? EDGE_TRAIL : EDGE_LEAD;
    endfunction

endpackage

// File: rtl/sync_ff2.sv
// Two-flop synchroniser for a single asynchronous input, with a
// configurable reset value so the output idles at the line's rest level.
module sync_ff2 #(
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta <= RST_VAL;
            q    <= RST_VAL;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/spi_target.sv
// SPI target (peripheral) oversampled on clk: all SPI pins are synchronised
// and the serial clock is edge-detected, so clk must run at least 4x slk.
//
// state     | meaning
// ----------+------------------------------------------------------
// ST_IDLE   | cs high (or not yet seen high after reset); slk ignored
// ST_ACTIVE | cs low; words are shifted in on pico and out on poci
module spi_target
    import spi_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter int CPOL      = 0,
    parameter int CPHA      = 0,
    parameter int MSB_FIRST = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             slk,
    input  logic             pico,
    input  logic             cs,
    output logic             poci,
    output logic             poci_oe,
    output logic [WIDTH-1:0] rx_data,
    output logic             rx_valid,
    input  logic             rx_ready,
    input  logic [WIDTH-1:0] tx_data,
    input  logic             tx_valid,
    output logic             tx_ready,
    output logic             rx_overrun,
    output logic             tx_underrun,
    output logic             busy
);

    localparam logic       IDLE_LVL    = (CPOL != 0);
    localparam logic       MSB         = (MSB_FIRST != 0);
    localparam logic       SAMPLE_EDGE = sample_edge_sel(CPHA);
    localparam logic [5:0] LAST_BIT    = 6'(WIDTH - 1);

    logic slk_s, cs_s, pico_s;
    logic slk_q, cs_q;
    logic lead, trail, sample, shift;
    logic cs_fall, cs_rise, load, advance;
    logic [0:0] state;
    logic [5:0] bit_cnt;
    logic [1:0] flush_cnt;
    logic armed;
    logic word_done;
    logic hold_full;
    logic [WIDTH-1:0] rx_shift, tx_shift, hold_data;

    sync_ff2 #(.RST_VAL(IDLE_LVL)) u_sync_slk  (.clk(clk), .rst_n(rst_n), .d(slk),  .q(slk_s));
    sync_ff2 #(.RST_VAL(1'b1))     u_sync_cs   (.clk(clk), .rst_n(rst_n), .d(cs),   .q(cs_s));
    sync_ff2 #(.RST_VAL(1'b0))     u_sync_pico (.clk(clk), .rst_n(rst_n), .d(pico), .q(pico_s));

    assign lead   = (slk_q == IDLE_LVL) && (slk_s != IDLE_LVL);
    assign trail  = (slk_q != IDLE_LVL) && (slk_s == IDLE_LVL);
    assign sample = (SAMPLE_EDGE == EDGE_TRAIL) ? trail : lead;
    assign shift  = (SAMPLE_EDGE == EDGE_TRAIL) ? lead : trail;

    // A cs that is already low when reset releases must not start a frame.
    assign cs_fall = armed && cs_q && !cs_s;
    assign cs_rise = !cs_q && cs_s;

    assign load = ((state == ST_IDLE) && cs_fall) ||
                  ((state == ST_ACTIVE) && !cs_rise && sample && (bit_cnt == LAST_BIT));

    // bit_cnt == 0 marks the shift edge that would skip over bit 0 of a fresh word.
    assign advance = (state == ST_ACTIVE) && !cs_rise && shift && (bit_cnt != 6'd0);

    assign poci     = MSB ? tx_shift[WIDTH-1] : tx_shift[0];
    assign poci_oe  = !cs_s;
    assign busy     = (state == ST_ACTIVE);
    assign tx_ready = !hold_full;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            slk_q     <= IDLE_LVL;
            cs_q      <= 1'b1;
            flush_cnt <= 2'd0;
            armed     <= 1'b0;
        end else begin
            slk_q <= slk_s;
            cs_q  <= cs_s;
            if (flush_cnt != 2'd3) flush_cnt <= flush_cnt + 2'd1;
            if ((flush_cnt == 2'd3) && cs_s) armed <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            bit_cnt   <= 6'd0;
            rx_shift  <= '0;
            word_done <= 1'b0;
        end else begin
            word_done <= 1'b0;
            if (state == ST_IDLE) begin
                if (cs_fall) begin
                    state   <= ST_ACTIVE;
                    bit_cnt <= 6'd0;
                end
            end else if (cs_rise) begin
                state   <= ST_IDLE;
                bit_cnt <= 6'd0;
            end else if (sample) begin
                rx_shift <= MSB ? {rx_shift[WIDTH-2:0], pico_s} : {pico_s, rx_shift[WIDTH-1:1]};
                if (bit_cnt == LAST_BIT) begin
                    bit_cnt   <= 6'd0;
                    word_done <= 1'b1;
                end else begin
                    bit_cnt <= bit_cnt + 6'd1;
                end
            end
        end
    end

    // A load coinciding with a write takes the old (empty) content.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_shift    <= '0;
            hold_data   <= '0;
            hold_full   <= 1'b0;
            tx_underrun <= 1'b0;
        end else begin
            tx_underrun <= load && !hold_full;
            if (load)
                tx_shift <= hold_full ? hold_data : '0;
            else if (advance)
                tx_shift <= MSB ? {tx_shift[WIDTH-2:0], 1'b0} : {1'b0, tx_shift[WIDTH-1:1]};
            if (tx_valid && !hold_full) begin
                hold_data <= tx_data;
                hold_full <= 1'b1;
            end else if (load) begin
                hold_full <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_data    <= '0;
            rx_valid   <= 1'b0;
            rx_overrun <= 1'b0;
        end else begin
            rx_overrun <= 1'b0;
            if (word_done) begin
                if (rx_valid && !rx_ready) begin
                    rx_overrun <= 1'b1;
                end else begin
                    rx_data  <= rx_shift;
                    rx_valid <= 1'b1;
                end
            end else if (rx_valid && rx_ready) begin
                rx_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_spi_target.sv
// Bench for spi_target: five instances cover modes 0-3 (MSB first) and
// mode 0 LSB first; a bit-level SPI controller drives one instance at a time.
module tb_spi_target;

    localparam int NI = 5;
    localparam int H  = 8;
    localparam int CPOL_T [NI] = '{0, 0, 1, 1, 0};
    localparam int CPHA_T [NI] = '{0, 1, 0, 1, 0};
    localparam int MSB_T  [NI] = '{1, 1, 1, 1, 0};

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic slk [NI];
    logic pico [NI];
    logic cs [NI];
    logic poci [NI];
    logic poci_oe [NI];
    logic rx_valid [NI];
    logic rx_ready [NI];
    logic tx_valid [NI];
    logic tx_ready [NI];
    logic rx_overrun [NI];
    logic tx_underrun [NI];
    logic busy [NI];
    logic [7:0] rx_data [NI];
    logic [7:0] tx_data [NI];

    always #5 clk = ~clk;

    for (genvar g = 0; g < NI; g++) begin : g_dut
        spi_target #(
            .WIDTH(8), .CPOL(CPOL_T[g]), .CPHA(CPHA_T[g]), .MSB_FIRST(MSB_T[g])
        ) u_dut (
            .clk(clk), .rst_n(rst_n), .slk(slk[g]), .pico(pico[g]), .cs(cs[g]),
            .poci(poci[g]), .poci_oe(poci_oe[g]), .rx_data(rx_data[g]),
            .rx_valid(rx_valid[g]), .rx_ready(rx_ready[g]), .tx_data(tx_data[g]),
            .tx_valid(tx_valid[g]), .tx_ready(tx_ready[g]), .rx_overrun(rx_overrun[g]),
            .tx_underrun(tx_underrun[g]), .busy(busy[g])
        );
    end

    int cur = 0;
    int tests = 0;
    int fails = 0;
    int ovr = 0;
    int und = 0;
    bit pend = 1'b0;
    logic [7:0] txq [$];
    logic [7:0] rxq [$];
    logic [7:0] rxw [4];
    logic [7:0] txw [4];
    logic [7:0] cap [4];

    // Application side: feeds the tx holding register from txq and logs
    // every accepted rx word and every error pulse of the current instance.
    always @(negedge clk) begin
        if (pend) begin
            void'(txq.pop_front());
            pend = 1'b0;
        end
        for (int k = 0; k < NI; k++) begin
            tx_valid[k] = 1'b0;
            tx_data[k]  = 8'h00;
        end
        if (txq.size() > 0) begin
            tx_valid[cur] = 1'b1;
            tx_data[cur]  = txq[0];
        end
        if (rst_n && tx_valid[cur] && tx_ready[cur]) pend = 1'b1;
        if (rx_valid[cur] && rx_ready[cur]) rxq.push_back(rx_data[cur]);
        if (rx_overrun[cur]) ovr++;
        if (tx_underrun[cur]) und++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic send_bits(input logic [7:0] w, input int nb, output logic [7:0] c);
        int k;
        logic idl, b, cpha, msb;
        k    = cur;
        idl  = (CPOL_T[k] != 0);
        cpha = (CPHA_T[k] != 0);
        msb  = (MSB_T[k] != 0);
        c    = 8'h00;
        for (int i = 0; i < nb; i++) begin
            b = msb ? w[7-i] : w[i];
            if (!cpha) begin
                pico[k] = b;
                repeat (H) @(negedge clk);
                slk[k] = !idl;
                c = msb ? {c[6:0], poci[k]} : {poci[k], c[7:1]};
                repeat (H) @(negedge clk);
                slk[k] = idl;
            end else begin
                slk[k]  = !idl;
                pico[k] = b;
                repeat (H) @(negedge clk);
                slk[k] = idl;
                c = msb ? {c[6:0], poci[k]} : {poci[k], c[7:1]};
                repeat (H) @(negedge clk);
            end
        end
    endtask

    // late: tx words are queued only after the frame has started, so the
    // entry load finds an empty holding register.
    task automatic run_frame(input int n, input bit late, input bit rdy_low);
        int k, rb, o0, u0;
        logic [7:0] exp_cap;
        k  = cur;
        rb = rxq.size();
        o0 = ovr;
        u0 = und;
        rx_ready[k] = !rdy_low;
        if (!late) for (int i = 0; i <= n; i++) txq.push_back(txw[i]);
        repeat (4*H) @(negedge clk);
        cs[k] = 1'b0;
        repeat (H) @(negedge clk);
        check("busy_in_frame", busy[k], 1);
        if (late) for (int i = 0; i < n; i++) txq.push_back(txw[i]);
        for (int i = 0; i < n; i++) send_bits(rxw[i], 8, cap[i]);
        repeat (H) @(negedge clk);
        cs[k] = 1'b1;
        repeat (2*H) @(negedge clk);
        check("busy_after_frame", busy[k], 0);
        for (int i = 0; i < n; i++) begin
            if (late) exp_cap = (i == 0) ? 8'h00 : txw[i-1];
            else      exp_cap = txw[i];
            check("poci_word", cap[i], exp_cap);
        end
        check("underrun_count", und - u0, late ? 1 : 0);
        if (!rdy_low) begin
            check("rx_word_count", rxq.size() - rb, n);
            for (int i = 0; i < n; i++)
                if (rxq.size() > rb + i) check("rx_word", rxq[rb+i], rxw[i]);
            check("overrun_count", ovr - o0, 0);
        end else begin
            check("rx_valid_held", rx_valid[k], 1);
            check("rx_data_first", rx_data[k], rxw[0]);
            check("overrun_count", ovr - o0, n - 1);
            check("rx_none_taken", rxq.size() - rb, 0);
            rx_ready[k] = 1'b1;
            repeat (4) @(negedge clk);
            check("rx_late_count", rxq.size() - rb, 1);
            if (rxq.size() > rb) check("rx_late_word", rxq[rb], rxw[0]);
            check("rx_valid_clear", rx_valid[k], 0);
        end
    endtask

    initial begin
        int rb, n;
        logic [7:0] junk;
        for (int k = 0; k < NI; k++) begin
            slk[k]      = (CPOL_T[k] != 0);
            pico[k]     = 1'b0;
            cs[k]       = 1'b1;
            rx_ready[k] = 1'b1;
        end
        repeat (5) @(negedge clk);
        check("rst_rx_valid", rx_valid[0], 0);
        check("rst_rx_data", rx_data[0], 0);
        check("rst_tx_ready", tx_ready[0], 1);
        check("rst_poci", poci[0], 0);
        check("rst_poci_oe", poci_oe[0], 0);
        check("rst_busy", busy[0], 0);
        check("rst_errors", {rx_overrun[0], tx_underrun[0]}, 0);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);

        // Mode 0 basic transfer
        cur = 0;
        txw[0] = 8'h3C; txw[1] = 8'($urandom);
        rxw[0] = 8'hA5;
        run_frame(1, 1'b0, 1'b0);

        // Modes 1..3 directed plus random pairs
        for (int m = 1; m < 4; m++) begin
            cur = m;
            txw[0] = 8'h7E; txw[1] = 8'($urandom);
            rxw[0] = 8'h81;
            run_frame(1, 1'b0, 1'b0);
            for (int i = 0; i < 4; i++) begin
                txw[i] = 8'($urandom);
                rxw[i] = 8'($urandom);
            end
            run_frame(2, 1'b0, 1'b0);
        end

        // LSB-first instance
        cur = 4;
        txw[0] = 8'($urandom); txw[1] = 8'($urandom);
        rxw[0] = 8'h01;
        run_frame(1, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) begin
            txw[i] = 8'($urandom);
            rxw[i] = 8'($urandom);
        end
        run_frame(2, 1'b0, 1'b0);

        // Three words in one frame
        cur = 0;
        rxw[0] = 8'h11; rxw[1] = 8'h22; rxw[2] = 8'h33;
        for (int i = 0; i < 4; i++) txw[i] = 8'($urandom);
        run_frame(3, 1'b0, 1'b0);

        // Overrun: rx_ready low across two words
        for (int i = 0; i < 4; i++) begin
            txw[i] = 8'($urandom);
            rxw[i] = 8'($urandom);
        end
        run_frame(2, 1'b0, 1'b1);

        // Underrun: holding register empty at frame start
        txw[0] = 8'($urandom);
        rxw[0] = 8'($urandom);
        run_frame(1, 1'b1, 1'b0);

        // cs released after 5 bits, then a full frame
        txq.push_back(8'($urandom));
        repeat (4*H) @(negedge clk);
        rb = rxq.size();
        cs[0] = 1'b0;
        repeat (H) @(negedge clk);
        send_bits(8'($urandom), 5, junk);
        cs[0] = 1'b1;
        repeat (2*H) @(negedge clk);
        check("abort_no_rx", rxq.size() - rb, 0);
        check("abort_rx_valid", rx_valid[0], 0);
        check("abort_idle", busy[0], 0);
        txw[0] = 8'($urandom); txw[1] = 8'($urandom);
        rxw[0] = 8'hC3;
        run_frame(1, 1'b0, 1'b0);

        // Reset in the middle of a frame
        txq.push_back(8'($urandom));
        repeat (4*H) @(negedge clk);
        cs[0] = 1'b0;
        repeat (H) @(negedge clk);
        send_bits(8'($urandom), 4, junk);
        rst_n = 1'b0;
        #1;
        check("midrst_rx_data", rx_data[0], 0);
        check("midrst_rx_valid", rx_valid[0], 0);
        check("midrst_tx_ready", tx_ready[0], 1);
        check("midrst_poci", poci[0], 0);
        check("midrst_oe_busy", {poci_oe[0], busy[0]}, 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (4*H) @(negedge clk);
        check("no_restart_low_cs", busy[0], 0);
        cs[0] = 1'b1;
        repeat (2*H) @(negedge clk);
        txw[0] = 8'($urandom); txw[1] = 8'($urandom);
        rxw[0] = 8'h5A;
        run_frame(1, 1'b0, 1'b0);

        // Random frames on random instances
        for (int r = 0; r < 5; r++) begin
            cur = $urandom_range(0, NI - 1);
            n = $urandom_range(1, 3);
            for (int i = 0; i < 4; i++) begin
                txw[i] = 8'($urandom);
                rxw[i] = 8'($urandom);
            end
            run_frame(n, 1'b0, 1'b0);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/spi_target.md
SPI_TARGET -- requirements
Module: spi_target

Interface
REQ-001 Parameter WIDTH, default 8: bits per word; legal range 4..32.
REQ-002 Parameter CPOL, default 0: idle level of slk.
REQ-003 Parameter CPHA, default 0: 0 = sample on leading edge, 1 = sample on trailing edge.
REQ-004 Parameter MSB_FIRST, default 1: 1 = MSB shifted first on both pico and poci; 0 = LSB first.
REQ-005 Port clk, input, 1 bit: the single system clock; all state is on its rising edge.
REQ-006 Port rst_n, input, 1 bit: reset, asynchronous assert, active-low.
REQ-007 Port slk, input, 1 bit: SPI serial clock from the controller; asynchronous to clk.
REQ-008 Port pico, input, 1 bit: serial data from the controller.
REQ-009 Port cs, input, 1 bit: chip select, active-low.
REQ-010 Port poci, output, 1 bit: serial data to the controller.
REQ-011 Port poci_oe, output, 1 bit: output enable for poci; high while the synchronised cs is low.
REQ-012 Port rx_data, output, WIDTH bits: last complete received word.
REQ-013 Port rx_valid, output, 1 bit, with rx_ready, input, 1 bit: receive handshake.
REQ-014 Port tx_data, input, WIDTH bits, with tx_valid, input, 1 bit, and tx_ready, output, 1 bit: transmit handshake.
REQ-015 Port rx_overrun, output, 1 bit; port tx_underrun, output, 1 bit: single-cycle error pulses.
REQ-016 Port busy, output, 1 bit: high while state is ACTIVE.

Function
REQ-017 slk, pico and cs SHALL each pass through a 2-flop synchroniser; edges SHALL be detected on the synchronised slk only. Required clk:slk ratio is at least 4.
REQ-018 Leading edge = synchronised slk leaving the CPOL level; trailing edge = synchronised slk returning to it. The sample edge is selected by CPHA; the shift edge is the opposite edge.
REQ-019 FSM states: IDLE and ACTIVE.
- IDLE -> ACTIVE on synchronised cs falling.
- ACTIVE -> IDLE on synchronised cs rising.
- slk edges in IDLE SHALL be ignored.
REQ-020 On entry to ACTIVE:
- bit counter cleared;
- tx shifter loaded from the holding register if it is full, else with 0 (tx_underrun pulses).
REQ-021 Each sample edge shifts pico into the rx shifter and increments the bit counter.
REQ-022 On the WIDTH-th sample:
- counter wraps to 0;
- the word is transferred to rx_data with rx_valid set one clk after the edge-detect cycle;
- a new tx word is loaded per REQ-020 rules.
Multiple words per cs frame SHALL be supported.
REQ-023 Each shift edge advances the poci bit. Exception when CPHA=1: the first shift edge of each word does not advance, because bit 0 is already presented.
REQ-024 poci SHALL be the current tx shifter bit (MSB or LSB per MSB_FIRST), valid from the load cycle.
REQ-025 rx_valid SHALL stay high until the cycle rx_valid&&rx_ready. If a word completes while rx_valid is high, that word is discarded, rx_data is unchanged, and rx_overrun pulses 1 cycle. If a word completes in the same cycle as the handshake, the new word is accepted.
REQ-026 tx_ready SHALL be high while the holding register is empty; the register is written on tx_valid&&tx_ready. If a load and a write occur in the same cycle, the load takes the old content and the write is accepted.
REQ-027 cs rising mid-word: the partial rx word is discarded, no rx_valid is raised, the bit counter is cleared, and the holding register is kept.
REQ-028 cs low for 0 slk edges: no rx_valid; a tx word loaded on entry is consumed.

Reset
REQ-029 rst_n low SHALL asynchronously force:
- state IDLE and all counters 0;
- synchronisers to idle values (slk=CPOL, cs=1, pico=0);
- rx_data=0, rx_valid=0, tx_ready=1, poci=0, poci_oe=0, busy=0, rx_overrun=0, tx_underrun=0.
REQ-030 Reset mid-frame SHALL abort the frame; after release the block resumes only on a fresh cs falling edge.

Structure
REQ-031 State encodings and the edge-select localparams SHALL live in shared package spi_pkg.
REQ-032 The synchroniser SHALL be a sub-module sync_ff2, instantiated three times. All other logic stays in spi_target.

Verification
REQ-033 Mode 0, WIDTH=8, tx 0x3C preloaded, controller sends 0xA5 -> rx_data=0xA5 with one rx_valid; controller captures 0x3C.
REQ-034 Each of modes 1, 2 and 3: send 0x81 while tx=0x7E -> both words correct; MSB_FIRST=0 variant sends 0x01 and receives bit-reversed order correctly.
REQ-035 One cs frame with 3 words 0x11, 0x22, 0x33, rx_ready held high, tx refilled each tx_ready -> 3 rx_valid pulses in order; no error pulses.
REQ-036 rx_ready held low over 2 words -> rx_data=first word; rx_overrun pulses once. Empty tx at frame start -> poci=0 and tx_underrun pulses once.
REQ-037 cs released after 5 bits, then a full frame 0xC3 -> only 0xC3 is reported.
REQ-038 rst_n asserted after bit 4 -> all outputs at reset values immediately; the next frame 0x5A is received correctly.
